// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle fetch/decode/execute sequencer with an accumulator.
// Fetches from IRAM and reads/writes DRAM over a request/ready handshake.
// Optional build macro: MC_ILLEGAL_TRAP_EN (undefined opcodes halt the
// machine and raise a sticky 'illegal' output instead of executing as NOP).
//
// Handshake: a request strobe (iram_rd, dram_rd, dram_wr) is raised in its
// state and held, together with its address/data, until the matching ready
// input is seen high in the same cycle; that cycle completes the transfer.
// A ready seen while the corresponding strobe is low is ignored.
module mc_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned PC_RESET = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_addr,
  output logic              iram_rd,
  input  logic              iram_ready,
  input  logic [DATA_W-1:0] iram_data,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_rd,
  output logic              dram_wr,
  input  logic              dram_ready,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [DATA_W-1:0] dram_wdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic [2:0]        state,
  output logic              halted
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDA  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_STA  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_HALT = {OPC_W{1'b1}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                halted_q, halted_d;
`ifdef MC_ILLEGAL_TRAP_EN
  logic                illegal_q, illegal_d;
`endif

  // Instruction fields decoded from the held instruction register.
  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   imm;

  assign opcode  = ir_q[DATA_W-1 -: OPC_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = DATA_W'(ir_q[DATA_W-OPC_W-1:0]);

  // State and datapath registers; reset wins in every state and drops any
  // outstanding request because the strobes are decoded from state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= ADDR_W'(PC_RESET);
      acc_q    <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next-state logic: handshake states wait for ready, DECODE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (iram_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP, OP_LDI, OP_JMP, OP_JZ:  state_d = S_FETCH;
          OP_LDA, OP_ADD, OP_SUB, OP_AND: state_d = S_MEM_RD;
          OP_STA:                         state_d = S_MEM_WR;
          OP_HALT:                        state_d = S_HALT;
`ifdef MC_ILLEGAL_TRAP_EN
          default:                        state_d = S_HALT;
`else
          default:                        state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_RD: if (dram_ready) state_d = S_FETCH;
      S_MEM_WR: if (dram_ready) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath updates: instruction load, pc advance/branch, accumulator ops.
  always_comb begin
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (iram_ready) begin
          ir_d = iram_data;
          pc_d = pc_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LDI:  acc_d = imm;
          OP_JMP:  pc_d  = operand;
          OP_JZ:   if (acc_q == '0) pc_d = operand;
          OP_HALT: halted_d = 1'b1;
          OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND: ;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            halted_d  = 1'b1;
            illegal_d = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_RD: begin
        if (dram_ready) begin
          case (opcode)
            OP_LDA:  acc_d = dram_rdata;
            OP_ADD:  acc_d = acc_q + dram_rdata;
            OP_SUB:  acc_d = acc_q - dram_rdata;
            OP_AND:  acc_d = acc_q & dram_rdata;
            default: acc_d = acc_q;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Output decode: strobes are a pure function of state, so at most one is high.
  always_comb begin
    iram_rd = 1'b0;
    dram_rd = 1'b0;
    dram_wr = 1'b0;
    case (state_q)
      S_FETCH:  iram_rd = 1'b1;
      S_MEM_RD: dram_rd = 1'b1;
      S_MEM_WR: dram_wr = 1'b1;
      default: ;
    endcase
  end

  assign iram_addr  = pc_q;
  assign dram_addr  = operand;
  assign dram_wdata = acc_q;
  assign pc_out     = pc_q;
  assign acc_out    = acc_q;
  assign state      = state_q;
  assign halted     = halted_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal    = illegal_q;
`endif

endmodule
